egress_queue: RTL and testbench

- Per-output egress buffer that sits directly downstream of switch_fabric_block. One instance is placed on each fabric output.
- Captures every valid word the fabric emits on its output lane into a FIFO and presents it to the consumer through a valid/ready handshake.
- The fabric has no backpressure, so a word that arrives when the queue is full is dropped and counted, never stalled.

---
 rtl/egress_queue.sv | 94 +++++++++
 tb/tb_egress_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/egress_queue.sv
// egress_queue: per-output show-ahead FIFO behind the switch fabric; words that arrive while full are dropped.
// Build option: define EGRESS_DROP_CNT_EN to build the saturating drop counter (otherwise drop_count reads 0).
module egress_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;
    logic                  push, pop;

    assign full      = (count_q == OCC_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    // A full queue still accepts a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; stale entries are never visible because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef EGRESS_DROP_CNT_EN
    logic                 drop;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    assign drop = in_valid && full && !pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_egress_queue.sv
// Self-checking bench for egress_queue: directed scenarios plus random traffic checked against a queue-based model.
// Expected drop_count follows the EGRESS_DROP_CNT_EN build option.
module tb_egress_queue;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int DROP_MAX   = (1 << CNT_WIDTH) - 1;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic [CNT_WIDTH-1:0]   drop_count;

    egress_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Reference model: arrival-ordered queue of words plus a saturating count of rejected words.
    logic [DATA_WIDTH-1:0] model_q [$];
    int                    model_drops = 0;

    function automatic void model_step(input logic v, input logic [DATA_WIDTH-1:0] d, input logic r);
        bit was_full = (model_q.size() == DEPTH);
        bit popped   = (model_q.size() != 0) && r;
        if (popped) void'(model_q.pop_front());
        if (v) begin
            if (!was_full || popped) model_q.push_back(d);
            else if (model_drops < DROP_MAX) model_drops++;
        end
    endfunction

    function automatic int exp_drops();
`ifdef EGRESS_DROP_CNT_EN
        return model_drops;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all(input string tag);
        int n = model_q.size();
        check({tag, ".out_valid"},  32'(out_valid),  32'(n != 0));
        check({tag, ".out_data"},   32'(out_data),   (n != 0) ? 32'(model_q[0]) : 32'd0);
        check({tag, ".count"},      32'(count),      32'(n));
        check({tag, ".full"},       32'(full),       32'(n == DEPTH));
        check({tag, ".empty"},      32'(empty),      32'(n == 0));
        check({tag, ".drop_count"}, 32'(drop_count), 32'(exp_drops()));
    endtask

    // Drives one cycle of stimulus in the low phase, steps the model at the edge, samples at the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [DATA_WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_step(v, d, r);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_junk(output logic [DATA_WIDTH-1:0] d);
        d = DATA_WIDTH'($urandom_range(0, 65535));
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] junk;
        int drops_before;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        compare_all("reset");

        // Single word, then a one-cycle pop.
        cycle("single_push", 1'b1, 16'd7, 1'b0);
        check("single_word", 32'(out_data), 32'd7);
        idle_junk(junk);
        cycle("single_pop", 1'b0, junk, 1'b1);
        check("single_empty", 32'(empty), 32'd1);

        // Fill past capacity with the consumer stalled.
        for (int i = 1; i <= 10; i++) begin
            cycle("fill", 1'b1, DATA_WIDTH'(i), 1'b0);
            if (i == 8) check("fill_full_at_8", 32'(count), 32'd8);
        end
        check("overflow_drops", 32'(drop_count), 32'(exp_drops()));
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 32'(out_data), 32'(i));
            idle_junk(junk);
            cycle("drain", 1'b0, junk, 1'b1);
        end

        // Full queue with simultaneous push and pop.
        for (int i = 1; i <= 8; i++) cycle("refill", 1'b1, DATA_WIDTH'(i), 1'b0);
        drops_before = exp_drops();
        cycle("full_push_pop", 1'b1, 16'd20, 1'b1);
        check("full_pp_head", 32'(out_data), 32'd2);
        check("full_pp_count", 32'(count), 32'd8);
        check("full_pp_drops", 32'(drop_count), 32'(drops_before));
        for (int i = 0; i < 8; i++) begin
            check("full_pp_drain", 32'(out_data), (i < 7) ? 32'(i + 2) : 32'd20);
            idle_junk(junk);
            cycle("full_pp_drain_step", 1'b0, junk, 1'b1);
        end

        // Streaming through the pointer wrap with the consumer always ready.
        for (int i = 0; i < 32; i++) begin
            cycle("stream", 1'b1, DATA_WIDTH'(i), 1'b1);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_count_le1", 32'(count <= 1), 32'd1);
        end
        idle_junk(junk);
        cycle("stream_tail", 1'b0, junk, 1'b1);

        // Asynchronous reset pulse in the middle of operation.
        for (int i = 0; i < 5; i++) cycle("pre_reset", 1'b1, DATA_WIDTH'(100 + i), 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_q.delete();
        model_drops = 0;
        compare_all("mid_reset");
        #4 rst = 1'b1;
        cycle("post_reset_push", 1'b1, 16'd42, 1'b0);
        check("post_reset_data", 32'(out_data), 32'd42);
        check("post_reset_count", 32'(count), 32'd1);

        // Hold the queue full and keep offering words to saturate the drop counter.
        for (int i = 0; i < 300; i++) cycle("saturate", 1'b1, DATA_WIDTH'($urandom_range(0, 65535)), 1'b0);
`ifdef EGRESS_DROP_CNT_EN
        check("saturate_255", 32'(drop_count), 32'd255);
`else
        check("drop_tied_zero", 32'(drop_count), 32'd0);
`endif

        // Randomised traffic in phases of varying consumer readiness.
        for (int phase = 0; phase < 8; phase++) begin
            int ready_pct = (phase % 4) * 30 + 5;
            int valid_pct = 70 - (phase % 3) * 20;
            for (int i = 0; i < 200; i++) begin
                logic v = ($urandom_range(0, 99) < valid_pct);
                logic r = ($urandom_range(0, 99) < ready_pct);
                cycle("random", v, DATA_WIDTH'($urandom_range(0, 65535)), r);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
